fetch_sequencer: RTL

- Sequences the instruction fetch path of the single-cycle ARM-subset CPU.
- Owns the program counter and drives the byte address into the combinational code memory.
- Registers each returned 32-bit instruction, with its PC, into an IF output stage for decode.
- Handles decode stalls, branch/BL redirects from execute, post-redirect bubbles, and halting when the PC leaves the populated code memory.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_pc_reg.sv | 34 +++
 rtl/fetch_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'hE1A0_0000;
  localparam logic [31:0] INST_BYTES = 32'd4;
  localparam int          BUBBLE_W   = 2;

  // Evaluated in 33 bits so an address near 2^32 cannot wrap into a pass.
  function automatic logic addr_legal(input logic [31:0] addr, input logic [32:0] mem_bytes);
    return ({1'b0, addr} + {1'b0, INST_BYTES}) <= mem_bytes;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Code-memory and IF-stage signal bundle between the fetch sequencer and its surroundings.
interface fetch_sequencer_if;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] if_inst_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus8_o;
  logic        if_valid_o;
  logic        halted_o;

  modport master (
    output pc_o, if_inst_o, if_pc_o, if_pc_plus8_o, if_valid_o, halted_o,
    input  inst_i, stall_i, branch_i, branch_target_i
  );

  modport slave (
    input  pc_o, if_inst_o, if_pc_o, if_pc_plus8_o, if_valid_o, halted_o,
    output inst_i, stall_i, branch_i, branch_target_i
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: aligned redirect load, sequential increment, or hold.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        incr,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_r;
  logic [31:0] target_aligned_s;

  assign target_aligned_s = target & 32'hFFFF_FFFC;
  assign pc               = pc_r;

  // PC update; load has priority over increment, increment wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= target_aligned_s;
    end else if (incr) begin
      pc_r <= pc_r + INST_BYTES;
    end else begin
      pc_r <= pc_r;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC ownership, IF output stage, redirect bubbles and out-of-range halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          MEM_BYTES      = 68,
  parameter int          BRANCH_BUBBLES = 0
) (
  input logic               clk,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam logic [32:0]         MEM_LIMIT   = 33'(MEM_BYTES);
  localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(BRANCH_BUBBLES);

  fetch_state_e        state_r, state_next_s;
  logic [BUBBLE_W-1:0] cnt_r, cnt_next_s;
  logic [31:0]         pc_s;
  logic                pc_load_s, pc_incr_s, capture_s;
  logic                valid_r, valid_next_s;
  logic                halted_r, halted_next_s;
  logic [31:0]         if_inst_r, if_pc_r;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load_s),
    .incr   (pc_incr_s),
    .target (bus.branch_target_i),
    .pc     (pc_s)
  );

  // State, bubble counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RUN;
      cnt_r    <= {BUBBLE_W{1'b0}};
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      valid_r  <= valid_next_s;
      halted_r <= halted_next_s;
    end
  end

  // Next-state logic; branch beats stall, stall freezes everything.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    pc_load_s     = 1'b0;
    pc_incr_s     = 1'b0;
    capture_s     = 1'b0;
    valid_next_s  = valid_r;
    halted_next_s = halted_r;
    if (bus.branch_i) begin
      pc_load_s     = 1'b1;
      valid_next_s  = 1'b0;
      halted_next_s = 1'b0;
      if (BUBBLE_LOAD == {BUBBLE_W{1'b0}}) begin
        state_next_s = ST_RUN;
      end else begin
        state_next_s = ST_FLUSH;
        cnt_next_s   = BUBBLE_LOAD;
      end
    end else if (bus.stall_i) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (addr_legal(pc_s, MEM_LIMIT)) begin
            capture_s    = 1'b1;
            pc_incr_s    = 1'b1;
            valid_next_s = 1'b1;
          end else begin
            valid_next_s  = 1'b0;
            halted_next_s = 1'b1;
            state_next_s  = ST_HALT;
          end
        end
        ST_FLUSH: begin
          valid_next_s = 1'b0;
          cnt_next_s   = cnt_r - {{(BUBBLE_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(BUBBLE_W-1){1'b0}}, 1'b1}) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_FLUSH;
          end
        end
        ST_HALT: begin
          valid_next_s  = 1'b0;
          halted_next_s = 1'b1;
        end
        default: begin
          valid_next_s = 1'b0;
          state_next_s = ST_RUN;
        end
      endcase
    end
  end

  // IF stage payload; held whenever no fetch is captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_inst_r <= NOP_INST;
      if_pc_r   <= 32'h0000_0000;
    end else if (capture_s) begin
      if_inst_r <= bus.inst_i;
      if_pc_r   <= pc_s;
    end else begin
      if_inst_r <= if_inst_r;
      if_pc_r   <= if_pc_r;
    end
  end

  assign bus.pc_o          = pc_s;
  assign bus.if_inst_o     = if_inst_r;
  assign bus.if_pc_o       = if_pc_r;
  assign bus.if_pc_plus8_o = if_pc_r + 32'd8;
  assign bus.if_valid_o    = valid_r;
  assign bus.halted_o      = halted_r;

endmodule
